// File: rtl/ex_stage_pipe.sv
// Execute-stage pipeline register: two-entry skid buffer, registered
// branch-redirect flush and later-stage kill.
// Ports: clk, rst (async, active-high); in_* upstream handshake and
// payload; out_* downstream handshake and payload; kill; flush and
// flush_target redirect. With EX_STAGE_PERF_CNT_EN defined, the
// saturating counters stall_cnt and flush_cnt are also present.
module ex_stage_pipe #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               in_br_taken,
   input  logic [PC_W-1:0]    in_br_target,
   input  logic               kill,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic               flush,
   output logic [PC_W-1:0]    flush_target
`ifdef EX_STAGE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
`endif
);

   logic               main_valid_q, main_valid_d;
   logic [PC_W-1:0]    main_pc_q, main_pc_d;
   logic [INSTR_W-1:0] main_instr_q, main_instr_d;
   logic               skid_valid_q, skid_valid_d;
   logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
   logic               flush_q, flush_d;
   logic [PC_W-1:0]    flush_target_q, flush_target_d;
   logic               acc, drn;

   // Wrong-path input is dropped while a redirect is on the wire.
   assign acc = in_valid & ~skid_valid_q & ~flush_q & ~kill;
   assign drn = main_valid_q & out_ready;

   always_comb begin
      main_valid_d   = main_valid_q;
      main_pc_d      = main_pc_q;
      main_instr_d   = main_instr_q;
      skid_valid_d   = skid_valid_q;
      skid_pc_d      = skid_pc_q;
      skid_instr_d   = skid_instr_q;
      flush_target_d = flush_target_q;
      flush_d        = acc & in_br_taken;
      if (kill) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         if (drn | ~main_valid_q) begin
            if (skid_valid_q) begin
               main_valid_d = 1'b1;
               main_pc_d    = skid_pc_q;
               main_instr_d = skid_instr_q;
               skid_valid_d = 1'b0;
            end else if (acc) begin
               main_valid_d = 1'b1;
               main_pc_d    = in_pc;
               main_instr_d = in_instr;
            end else begin
               main_valid_d = 1'b0;
            end
         end
         // acc implies skid empty, so this never overwrites a valid skid.
         if (acc & main_valid_q & ~out_ready) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = in_pc;
            skid_instr_d = in_instr;
         end
      end
      if (flush_d) flush_target_d = in_br_target;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q   <= 1'b0;
         main_pc_q      <= '0;
         main_instr_q   <= '0;
         skid_valid_q   <= 1'b0;
         skid_pc_q      <= '0;
         skid_instr_q   <= '0;
         flush_q        <= 1'b0;
         flush_target_q <= '0;
      end else begin
         main_valid_q   <= main_valid_d;
         main_pc_q      <= main_pc_d;
         main_instr_q   <= main_instr_d;
         skid_valid_q   <= skid_valid_d;
         skid_pc_q      <= skid_pc_d;
         skid_instr_q   <= skid_instr_d;
         flush_q        <= flush_d;
         flush_target_q <= flush_target_d;
      end
   end

   assign in_ready     = ~skid_valid_q;
   assign out_valid    = main_valid_q;
   assign out_pc       = main_pc_q;
   assign out_instr    = main_instr_q;
   assign flush        = flush_q;
   assign flush_target = flush_target_q;

`ifdef EX_STAGE_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (main_valid_q & ~out_ready & (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CntOne;
      if (flush_q & (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CntOne;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue model.
module tb_ex_stage_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [31:0] in_instr = '0;
   logic        in_br_taken = 1'b0;
   logic [31:0] in_br_target = '0;
   logic        kill = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        flush;
   logic [31:0] flush_target;
`ifdef EX_STAGE_PERF_CNT_EN
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;
`endif

   int checks = 0;
   int errors = 0;

   ex_stage_pipe dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_pc        (in_pc),
      .in_instr     (in_instr),
      .in_br_taken  (in_br_taken),
      .in_br_target (in_br_target),
      .kill         (kill),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_instr    (out_instr),
      .flush        (flush),
      .flush_target (flush_target)
`ifdef EX_STAGE_PERF_CNT_EN
      ,
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Behavioural model: the stage is an ordered queue of at most two
   // instructions; head is what out_* shows.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   logic        m_flush;
   logic [31:0] m_target;
   int unsigned m_stall;
   int unsigned m_fcnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_flush  = 1'b0;
         m_target = '0;
         m_stall  = 0;
         m_fcnt   = 0;
      end else begin
         bit a;
         ent_t e;
         if (mq.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
         if (m_flush && m_fcnt < 65535) m_fcnt++;
         a = in_valid && mq.size() < 2 && !m_flush && !kill;
         if (kill) begin
            mq.delete();
            m_flush = 1'b0;
         end else begin
            if (out_ready && mq.size() > 0) void'(mq.pop_front());
            if (a) begin
               e.pc    = in_pc;
               e.instr = in_instr;
               mq.push_back(e);
            end
            m_flush = a && in_br_taken;
            if (m_flush) m_target = in_br_target;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
         check("m_in_ready", 64'(in_ready), 64'(mq.size() < 2));
         check("m_flush", 64'(flush), 64'(m_flush));
         if (mq.size() > 0) begin
            check("m_out_pc", 64'(out_pc), 64'(mq[0].pc));
            check("m_out_instr", 64'(out_instr), 64'(mq[0].instr));
         end
         if (m_flush)
            check("m_flush_target", 64'(flush_target), 64'(m_target));
`ifdef EX_STAGE_PERF_CNT_EN
         check("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
         check("m_flush_cnt", 64'(flush_cnt), 64'(m_fcnt));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input logic [31:0] pc,
                      input logic br, input logic [31:0] tgt);
      in_valid     = v;
      in_pc        = pc;
      in_instr     = pc ^ 32'hA5A5_0000;
      in_br_taken  = br;
      in_br_target = tgt;
   endtask

   initial begin
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_pc", 64'(out_pc), 64'd0);
      check("rst_out_instr", 64'(out_instr), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_flush", 64'(flush), 64'd0);
      check("rst_flush_target", 64'(flush_target), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // Streaming
      out_ready = 1'b1;
      put(1, 32'h00, 0, 0); step();
      check("str_pc0", 64'(out_pc), 64'h00);
      check("str_rdy0", 64'(in_ready), 64'd1);
      put(1, 32'h04, 0, 0); step();
      check("str_pc1", 64'(out_pc), 64'h04);
      put(1, 32'h08, 0, 0); step();
      check("str_pc2", 64'(out_pc), 64'h08);
      check("str_instr2", 64'(out_instr), 64'hA5A5_0008);
      check("str_rdy2", 64'(in_ready), 64'd1);
      put(0, 0, 0, 0); step();
      check("str_empty", 64'(out_valid), 64'd0);

      // Backpressure
      out_ready = 1'b0;
      put(1, 32'h10, 0, 0); step();
      check("bp_pc0", 64'(out_pc), 64'h10);
      check("bp_rdy0", 64'(in_ready), 64'd1);
      put(1, 32'h14, 0, 0); step();
      check("bp_hold", 64'(out_pc), 64'h10);
      check("bp_full", 64'(in_ready), 64'd0);
      put(0, 0, 0, 0); out_ready = 1'b1; step();
      check("bp_pc1", 64'(out_pc), 64'h14);
      check("bp_rdy1", 64'(in_ready), 64'd1);
      step();
      check("bp_empty", 64'(out_valid), 64'd0);

      // Branch redirect
      put(1, 32'h20, 1, 32'h100); step();
      check("br_flush", 64'(flush), 64'd1);
      check("br_target", 64'(flush_target), 64'h100);
      check("br_pc", 64'(out_pc), 64'h20);
      put(1, 32'h24, 0, 0); step();
      check("br_flush_off", 64'(flush), 64'd0);
      check("br_dropped", 64'(out_valid), 64'd0);
      put(0, 0, 0, 0);

      // Kill while full, then kill cancels a same-cycle redirect
      out_ready = 1'b0;
      put(1, 32'h30, 0, 0); step();
      put(1, 32'h34, 0, 0); step();
      check("kf_full", 64'(in_ready), 64'd0);
      put(0, 0, 0, 0); kill = 1'b1; step();
      check("kf_valid", 64'(out_valid), 64'd0);
      check("kf_rdy", 64'(in_ready), 64'd1);
      check("kf_flush", 64'(flush), 64'd0);
      put(1, 32'h40, 1, 32'h400); step();
      check("kr_flush", 64'(flush), 64'd0);
      check("kr_valid", 64'(out_valid), 64'd0);
      kill = 1'b0; put(0, 0, 0, 0);

      // Async reset mid-stall with a pending flush
      put(1, 32'h50, 0, 0); step();
      put(1, 32'h54, 1, 32'h300); step();
      check("ar_pre_flush", 64'(flush), 64'd1);
      check("ar_pre_full", 64'(in_ready), 64'd0);
      put(0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      check("ar_valid", 64'(out_valid), 64'd0);
      check("ar_rdy", 64'(in_ready), 64'd1);
      check("ar_flush", 64'(flush), 64'd0);
      check("ar_pc", 64'(out_pc), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      step();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         put(1'($urandom_range(0, 3) != 0), $urandom,
             1'($urandom_range(0, 3) == 0), $urandom);
         in_instr  = $urandom;
         out_ready = 1'($urandom_range(0, 2) != 0);
         kill      = 1'($urandom_range(0, 19) == 0);
         step();
      end
      put(0, 0, 0, 0);
      kill = 1'b0;
      out_ready = 1'b1;
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised execute-stage pipeline register for the in-order core. It sits between decode/issue and memory access. It carries PC and instruction forward under a valid/ready handshake, using a two-entry skid buffer so backpressure never forms a combinational ready path. It drives a real, registered branch-redirect flush in place of a tied-off flush, and honours a kill request from later stages.

## Interface
Parameters:
- PC_W, 32, PC and branch-target width.
- INSTR_W, 32, instruction word width.
- CNT_W, 16, performance counter width (used only with the configuration macro).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept; equals !skid_valid (registered).
- in_pc  in  PC_W  PC of presented instruction.
- in_instr  in  INSTR_W  presented instruction word.
- in_br_taken  in  1  presented instruction is a resolved taken branch.
- in_br_target  in  PC_W  redirect target; valid with in_br_taken.
- kill  in  1  later-stage kill; discards all held entries.
- out_valid  out  1  main entry holds an instruction.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  PC of main entry.
- out_instr  out  INSTR_W  instruction of main entry.
- flush  out  1  one-cycle redirect pulse to fetch/decode.
- flush_target  out  PC_W  redirect PC; valid while flush=1.
- stall_cnt  out  CNT_W  present only with EX_STAGE_PERF_CNT_EN.
- flush_cnt  out  CNT_W  present only with EX_STAGE_PERF_CNT_EN.

## Operation
- Storage: main entry (main_valid, pc, instr) and skid entry (skid_valid, pc, instr). out_* are driven directly from main.
- Accept: acc = in_valid & in_ready & !flush & !kill.
- Drain: drn = main_valid & out_ready.
- Main update:
  - If drn or !main_valid: main loads skid if skid_valid, else loads the input if acc, else main_valid goes to 0.
  - Otherwise main holds.
- Skid update:
  - Skid loads the input when acc & main_valid & !out_ready.
  - Skid clears when main loads from it.
  - Skid is never overwritten while valid; in_ready=0 guarantees this.
- Ordering: instructions leave in exact acceptance order. No duplication and no loss except by flush or kill.
- Branch redirect:
  - If acc & in_br_taken, the next cycle has flush=1 and flush_target=in_br_target.
  - The branch itself is stored and forwarded normally.
- Wrong path: in any cycle with flush=1, in_valid data is dropped (acc=0) while in_ready still reflects skid state. Back-to-back flush pulses are therefore impossible.
- Kill:
  - Clears main_valid and skid_valid at the next edge.
  - No accept that cycle.
  - Forces flush to 0 at the next edge.
  - Kill overrides drain, accept and redirect.
- Data registers of invalid entries may hold stale values. Only the valid bits are architecturally meaningful.

## Timing
- Reset values: out_valid=0, out_pc=0, out_instr=0, in_ready=1, flush=0, flush_target=0, all counters 0. Skid data is also 0.
- Latency: an instruction accepted into an empty stage appears on out_* the following cycle.
- Throughput: 1 instruction/cycle while out_ready=1.
- in_ready depends only on registered state. There is no combinational path from out_ready or in_valid to in_ready.
- Flush: asserted exactly 1 cycle after the accepting edge, for exactly 1 cycle.
- Full condition: main and skid both valid. in_ready=0 until a drain moves skid into main.
- Simultaneous cases:
  - Drain + accept with skid empty: main is replaced by the input.
  - Drain + accept with skid valid: cannot occur, because in_ready=0.
- Reset mid-operation: all state returns to reset values immediately, independent of clk.

## Configuration
- EX_STAGE_PERF_CNT_EN defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments on each cycle with flush=1.
  - Both saturate at 2^CNT_W-1 and are cleared by rst only.
- Not defined: stall_cnt and flush_cnt ports and their logic are absent; all other behaviour is identical.

## Test plan
- Streaming: out_ready=1, send PCs 0x00,0x04,0x08 on consecutive cycles -> identical sequence on out_pc one cycle later each, in_ready stays 1.
- Backpressure: hold out_ready=0, send PCs 0x10,0x14 -> out_pc=0x10 held, in_ready=0 after second accept. Release -> 0x10 then 0x14 out, in_ready returns to 1.
- Branch: accept PC 0x20 with in_br_taken=1, target 0x100, then present 0x24 the next cycle -> flush=1 for one cycle with flush_target=0x100; 0x24 dropped; 0x20 forwarded.
- Kill while full: both entries valid, kill=1 -> next cycle out_valid=0, in_ready=1, flush=0. A pending redirect from the same cycle is cancelled.
- Async reset mid-stall: assert rst between edges while full -> out_valid=0, flush=0, in_ready=1 immediately.
- With EX_STAGE_PERF_CNT_EN: 5 stall cycles and 2 branches -> stall_cnt=5, flush_cnt=2. With CNT_W=2, 6 stalls -> stall_cnt=3.
